// File: rtl/slip_tx_arb.sv
// slip_tx_arb: frame-granular round-robin arbiter that shares one SLIP
// transmit path among N_REQ valid/ready byte-stream requesters. A grant is
// held from the first beat until the frame's last byte is accepted, then
// priority rotates to the requester after the one just served.
// Optional feature: define SLIP_TX_ARB_TIMEOUT_EN to abort a granted frame
// whose requester starves the link for TIMEOUT_CYC consecutive cycles.
module slip_tx_arb #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     frame_abort,
  output logic [15:0]              frame_cnt
);

  localparam int GW = $clog2(N_REQ);

  // Parameter sanity: requester count and a stall limit that fits the 16-bit counter.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("slip_tx_arb: N_REQ must be 2..8 and TIMEOUT_CYC 1..65535");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   cand;
  logic            pick_found;
  logic            xfer;
  logic            frame_done;
  logic            timeout_hit;
  logic [7:0]      byte_arr [N_REQ];

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      byte_arr[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin pick: first valid requester starting just after last_grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % N_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Zero-latency output mux; everything is forced low outside STREAM.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    req_ready = '0;
    if (state == STREAM) begin
      out_data            = byte_arr[grant_id];
      out_valid           = req_valid[grant_id];
      out_last            = req_last[grant_id];
      req_ready[grant_id] = out_ready;
    end
  end

  assign xfer       = out_valid & out_ready;
  assign frame_done = xfer & out_last;
  assign busy       = (state == STREAM);

`ifdef SLIP_TX_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        stalled;

  // Only a silent grantee counts as a stall; downstream backpressure does not.
  assign stalled     = (state == STREAM) && !req_valid[grant_id];
  assign timeout_hit = stalled && (stall_cnt == 16'(TIMEOUT_CYC - 1));

  // Count consecutive starved cycles; the abort pulse coincides with the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= timeout_hit;
      if (state != STREAM || xfer || timeout_hit) begin
        stall_cnt <= '0;
      end else if (stalled) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign frame_abort = 1'b0;
`endif

  // Next-state logic: grant on any request, release on last beat or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (pick_found) state_next = STREAM;
      STREAM: if (frame_done || timeout_hit) state_next = IDLE;
    endcase
  end

  // State, grant bookkeeping and frame counter.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(N_REQ - 1);
      frame_cnt  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_found) begin
        grant_id   <= pick_idx;
        last_grant <= pick_idx;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_slip_tx_arb.sv
// Testbench for slip_tx_arb: directed scenarios plus randomized traffic,
// every cycle compared against a frame-level reference model of the arbiter.
// Timeout checks are active when SLIP_TX_ARB_TIMEOUT_EN is defined.
module tb_slip_tx_arb;

  localparam int NR    = 4;
  localparam int TO    = 8;
  localparam int LOGSZ = 256;
  localparam int QSZ   = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [8*NR-1:0]  req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             frame_abort;
  logic [15:0]      frame_cnt;

  always #5 clk = ~clk;

  slip_tx_arb #(.N_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .frame_abort(frame_abort), .frame_cnt(frame_cnt)
  );

  int n_checks;
  int n_fail;

  // Requester sources: {last, data} per byte, consumed on req_valid & req_ready.
  logic [8:0] src_mem [NR][QSZ];
  int         src_head [NR];
  int         src_tail [NR];
  int         src_wait [NR];
  bit         rand_gaps;
  int         rdy_mode;
  logic       rdy_pat [16];

  // Reference model: owner of the link (-1 = none), previous grantee, counters.
  int   m_owner;
  int   m_prev;
  int   m_gid;
  int   m_frames;
  int   m_stall;
  logic m_abort;

  // Per-cycle log of observed outputs for directed checks.
  int         log_n;
  logic       log_busy  [LOGSZ];
  logic [1:0] log_gid   [LOGSZ];
  logic [7:0] log_data  [LOGSZ];
  logic       log_valid [LOGSZ];
  logic       log_last  [LOGSZ];
  logic       log_ordy  [LOGSZ];
  logic       log_abort [LOGSZ];
  logic [3:0] log_rdy   [LOGSZ];
  logic [15:0] log_cnt  [LOGSZ];

  function automatic void push_byte(int r, logic [7:0] d, logic l);
    src_mem[r][src_tail[r]] = {l, d};
    src_tail[r]++;
  endfunction

  function automatic void push_frame(int r, int len, logic [7:0] base);
    for (int k = 0; k < len; k++) push_byte(r, base + 8'(k), (k == len - 1));
  endfunction

  function automatic void clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      src_wait[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    m_owner  = -1;
    m_prev   = NR - 1;
    m_gid    = 0;
    m_frames = 0;
    m_stall  = 0;
    m_abort  = 1'b0;
  endfunction

  function automatic bit sources_empty();
    for (int i = 0; i < NR; i++) if (src_head[i] < src_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive, compare against the model, advance model and sources.
  task automatic cycle();
    logic [7:0]    e_data;
    logic          e_valid, e_last, e_busy, abort_next;
    logic [NR-1:0] e_rdy, pop;
    logic [1:0]    e_gid;
    for (int i = 0; i < NR; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
        req_last[i]        = src_mem[i][src_head[i]][8];
        req_valid[i]       = (src_wait[i] == 0);
      end else begin
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
        req_valid[i]       = 1'b0;
      end
    end
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = (log_n < 16) ? rdy_pat[log_n] : 1'b1;
    else                    out_ready = ($urandom_range(3) != 0);

    @(negedge clk);
    e_busy = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_data = 8'h00; e_rdy = '0;
    if (m_owner >= 0) begin
      e_busy         = 1'b1;
      e_valid        = req_valid[m_owner];
      e_last         = req_last[m_owner];
      e_data         = req_data[8*m_owner +: 8];
      e_rdy[m_owner] = out_ready;
    end
    e_gid = 2'(m_gid);

    n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL busy @%0t: got %0b want %0b", $time, busy, e_busy); end
    n_checks++; if (grant_id !== e_gid) begin n_fail++; $display("FAIL grant_id @%0t: got %0d want %0d", $time, grant_id, e_gid); end
    n_checks++; if (out_valid !== e_valid) begin n_fail++; $display("FAIL out_valid @%0t: got %0b want %0b", $time, out_valid, e_valid); end
    n_checks++; if (out_data !== e_data) begin n_fail++; $display("FAIL out_data @%0t: got %02h want %02h", $time, out_data, e_data); end
    n_checks++; if (out_last !== e_last) begin n_fail++; $display("FAIL out_last @%0t: got %0b want %0b", $time, out_last, e_last); end
    n_checks++; if (req_ready !== e_rdy) begin n_fail++; $display("FAIL req_ready @%0t: got %b want %b", $time, req_ready, e_rdy); end
    n_checks++; if (frame_cnt !== 16'(m_frames)) begin n_fail++; $display("FAIL frame_cnt @%0t: got %0d want %0d", $time, frame_cnt, 16'(m_frames)); end
    n_checks++; if (frame_abort !== m_abort) begin n_fail++; $display("FAIL frame_abort @%0t: got %0b want %0b", $time, frame_abort, m_abort); end

    if (log_n < LOGSZ) begin
      log_busy[log_n]  = busy;      log_gid[log_n]   = grant_id;
      log_data[log_n]  = out_data;  log_valid[log_n] = out_valid;
      log_last[log_n]  = out_last;  log_ordy[log_n]  = out_ready;
      log_abort[log_n] = frame_abort; log_rdy[log_n] = req_ready;
      log_cnt[log_n]   = frame_cnt;
    end
    pop = req_valid & req_ready;

    abort_next = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        if (m_owner < 0 && req_valid[(m_prev + k) % NR]) begin
          m_owner = (m_prev + k) % NR;
          m_prev  = m_owner;
          m_gid   = m_owner;
          m_stall = 0;
        end
      end
    end else if (req_valid[m_owner] && out_ready) begin
      m_stall = 0;
      if (req_last[m_owner]) begin
        m_frames = (m_frames + 1) % 65536;
        m_owner  = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_stall++;
`ifdef SLIP_TX_ARB_TIMEOUT_EN
      if (m_stall == TO) begin
        m_owner    = -1;
        abort_next = 1'b1;
      end
`endif
    end
    if (!rst) m_abort = abort_next;

    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (pop[i]) begin
        src_head[i]++;
        src_wait[i] = rand_gaps ? int'($urandom_range(2)) : 0;
      end else if (src_wait[i] > 0) begin
        src_wait[i]--;
      end
    end
    log_n++;
  endtask

  task automatic run_drain(int budget, string tag);
    int c = 0;
    while ((m_owner >= 0 || !sources_empty()) && c < budget) begin
      cycle();
      c++;
    end
    n_checks++;
    if (c >= budget) begin n_fail++; $display("FAIL drain_%s: still active after %0d cycles, want idle", tag, c); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_sources();
    log_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_sources();
    for (int r = 0; r < NR; r++) push_frame(r, 1, 8'hA0 + 8'(r));
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    log_n = 0;
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
    n_checks++; if (log_busy[0] !== 1'b0 || log_valid[0] !== 1'b0 || log_rdy[0] !== 4'b0) begin n_fail++; $display("FAIL reset_idle: busy=%0b valid=%0b ready=%b want 0", log_busy[0], log_valid[0], log_rdy[0]); end
    n_checks++; if (log_gid[0] !== 2'd0 || log_cnt[0] !== 16'd0 || log_data[0] !== 8'h00) begin n_fail++; $display("FAIL reset_values: gid=%0d cnt=%0d data=%02h want 0", log_gid[0], log_cnt[0], log_data[0]); end
    n_checks++; if (log_busy[1] !== 1'b0) begin n_fail++; $display("FAIL reset_latency: busy=%0b want 0 in arbitration cycle", log_busy[1]); end
    n_checks++; if (log_busy[2] !== 1'b1 || log_gid[2] !== 2'd0) begin n_fail++; $display("FAIL reset_priority: busy=%0b gid=%0d want 1/0", log_busy[2], log_gid[2]); end
    run_drain(100, "reset");
  endtask

  task automatic test_single_frame();
    do_reset();
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b0);
    push_byte(2, 8'h33, 1'b1);
    repeat (6) cycle();
    n_checks++; if (log_busy[1] !== 1'b1 || log_gid[1] !== 2'd2) begin n_fail++; $display("FAIL single_grant: busy=%0b gid=%0d want 1/2", log_busy[1], log_gid[1]); end
    n_checks++; if (log_data[1] !== 8'h11 || log_data[2] !== 8'h22 || log_data[3] !== 8'h33) begin n_fail++; $display("FAIL single_bytes: got %02h %02h %02h want 11 22 33", log_data[1], log_data[2], log_data[3]); end
    n_checks++; if (log_last[2] !== 1'b0 || log_last[3] !== 1'b1) begin n_fail++; $display("FAIL single_last: got %0b%0b want 01", log_last[2], log_last[3]); end
    n_checks++; if (log_busy[4] !== 1'b0 || log_cnt[4] !== 16'd1) begin n_fail++; $display("FAIL single_done: busy=%0b cnt=%0d want 0/1", log_busy[4], log_cnt[4]); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NR; r++) push_frame(r, 2, 8'((r << 4) | (f << 2)));
    repeat (16) cycle();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (log_gid[1 + 3*k] !== 2'(exp_order[k])) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, log_gid[1 + 3*k], exp_order[k]); end
    end
    for (int k = 0; k < 15; k++) begin
      n_checks++; if (log_busy[k] !== logic'(k % 3 != 0)) begin n_fail++; $display("FAIL rr_bubble[%0d]: busy=%0b want %0b", k, log_busy[k], (k % 3 != 0)); end
    end
    n_checks++; if (log_cnt[15] !== 16'd5) begin n_fail++; $display("FAIL rr_count: got %0d want 5", log_cnt[15]); end
    run_drain(100, "rr");
  endtask

  task automatic test_hold_grant();
    do_reset();
    push_frame(1, 4, 8'h40);
    cycle();
    cycle();
    push_frame(0, 1, 8'h05);
    repeat (6) cycle();
    for (int k = 2; k <= 5; k++) begin
      n_checks++; if (log_rdy[k][0] !== 1'b0) begin n_fail++; $display("FAIL hold_ready0[%0d]: got 1 want 0", k); end
    end
    n_checks++; if (log_gid[4] !== 2'd1 || log_last[4] !== 1'b1) begin n_fail++; $display("FAIL hold_last: gid=%0d last=%0b want 1/1", log_gid[4], log_last[4]); end
    n_checks++; if (log_busy[6] !== 1'b1 || log_gid[6] !== 2'd0 || log_rdy[6] !== 4'b0001) begin n_fail++; $display("FAIL hold_next: busy=%0b gid=%0d ready=%b want 1/0/0001", log_busy[6], log_gid[6], log_rdy[6]); end
    run_drain(50, "hold");
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    do_reset();
    rdy_pat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rdy_mode = 1;
    push_frame(1, 4, 8'hA1);
    repeat (8) cycle();
    rdy_mode = 0;
    for (int k = 0; k < 8; k++) if (log_valid[k] && log_ordy[k]) got.push_back(log_data[k]);
    n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d bytes want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_checks++; if (got[k] !== 8'hA1 + 8'(k)) begin n_fail++; $display("FAIL bp_byte[%0d]: got %02h want %02h", k, got[k], 8'hA1 + 8'(k)); end
    end
    for (int k = 1; k <= 6; k++) begin
      n_checks++; if (log_rdy[k][1] !== log_ordy[k]) begin n_fail++; $display("FAIL bp_mirror[%0d]: ready=%0b want %0b", k, log_rdy[k][1], log_ordy[k]); end
    end
    n_checks++; if (log_cnt[7] !== 16'd1) begin n_fail++; $display("FAIL bp_done: cnt=%0d want 1", log_cnt[7]); end
  endtask

  task automatic test_stall();
    do_reset();
    push_byte(3, 8'h5A, 1'b0);
    cycle();
    cycle();
    push_frame(0, 1, 8'hC0);
    repeat (12) cycle();
`ifdef SLIP_TX_ARB_TIMEOUT_EN
    n_checks++; if (log_abort[9] !== 1'b0 || log_abort[10] !== 1'b1 || log_abort[11] !== 1'b0) begin n_fail++; $display("FAIL to_pulse: abort[9..11]=%0b%0b%0b want 010", log_abort[9], log_abort[10], log_abort[11]); end
    n_checks++; if (log_busy[9] !== 1'b1 || log_busy[10] !== 1'b0) begin n_fail++; $display("FAIL to_idle: busy[9]=%0b busy[10]=%0b want 1/0", log_busy[9], log_busy[10]); end
    n_checks++; if (log_cnt[10] !== 16'd0) begin n_fail++; $display("FAIL to_count: cnt=%0d want 0", log_cnt[10]); end
    n_checks++; if (log_busy[11] !== 1'b1 || log_gid[11] !== 2'd0) begin n_fail++; $display("FAIL to_next: busy=%0b gid=%0d want 1/0", log_busy[11], log_gid[11]); end
`else
    for (int k = 2; k <= 13; k++) begin
      n_checks++; if (log_busy[k] !== 1'b1 || log_gid[k] !== 2'd3 || log_abort[k] !== 1'b0 || log_rdy[k][0] !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: busy=%0b gid=%0d abort=%0b rdy0=%0b want 1/3/0/0", k, log_busy[k], log_gid[k], log_abort[k], log_rdy[k][0]); end
    end
`endif
    push_byte(3, 8'h5B, 1'b1);
    run_drain(100, "stall");
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_frames: cnt=%0d want 2", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_frame(1, 1, 8'h77);
    repeat (3) cycle();
    push_frame(2, 3, 8'h90);
    log_n = 0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_sources();
    push_frame(3, 1, 8'hE3);
    push_frame(0, 1, 8'hE0);
    cycle();
    cycle();
    n_checks++; if (log_busy[2] !== 1'b1) begin n_fail++; $display("FAIL rmid_before: busy=%0b want 1", log_busy[2]); end
    n_checks++; if (log_busy[3] !== 1'b0 || log_cnt[3] !== 16'd0 || log_abort[3] !== 1'b0 || log_valid[3] !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: busy=%0b cnt=%0d abort=%0b valid=%0b want 0", log_busy[3], log_cnt[3], log_abort[3], log_valid[3]); end
    n_checks++; if (log_busy[4] !== 1'b1 || log_gid[4] !== 2'd0) begin n_fail++; $display("FAIL rmid_priority: busy=%0b gid=%0d want 1/0", log_busy[4], log_gid[4]); end
    run_drain(50, "rmid");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int total = 0;
      do_reset();
      rand_gaps = 1'b1;
      rdy_mode  = 2;
      for (int r = 0; r < NR; r++) begin
        int nf = $urandom_range(6, 3);
        for (int f = 0; f < nf; f++) begin
          int len = $urandom_range(4, 1);
          for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), (k == len - 1));
          total++;
        end
        src_wait[r] = $urandom_range(3);
      end
      run_drain(3000, "random");
      n_checks++; if (frame_cnt !== 16'(total)) begin n_fail++; $display("FAIL random_frames[%0d]: cnt=%0d want %0d", it, frame_cnt, total); end
      rand_gaps = 1'b0;
      rdy_mode  = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b1;
    rand_gaps = 1'b0;
    rdy_mode  = 0;
    log_n     = 0;
    clear_sources();
    model_reset();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_hold_grant();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slip_tx_arb.md
# slip_tx_arb

Frame-granular round-robin arbiter sharing one SLIP transmit path (encoder plus UART) among `N_REQ` byte-stream requesters. Each requester presents a frame as a valid/ready byte stream with a `last` marker. The arbiter grants one requester, holds the grant until that frame's last byte is accepted downstream, and then rotates priority. It sits between the command/response producers and the SLIP encoder feeding the UART transmitter.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYC`, 1024: stall cycles before a granted frame is aborted (used only with the config macro).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_data` in 8*N_REQ: byte of requester i at bits [8i+7:8i].
- `req_valid` in N_REQ: per-requester byte valid.
- `req_last` in N_REQ: per-requester last byte of frame, qualified by valid.
- `req_ready` out N_REQ: per-requester byte accepted.
- `out_data` out 8: byte to SLIP encoder.
- `out_valid` out 1: byte valid to encoder.
- `out_last` out 1: last byte of frame to encoder.
- `out_ready` in 1: encoder accepts byte.
- `grant_id` out $clog2(N_REQ): current or most recent grantee.
- `busy` out 1: high while in STREAM.
- `frame_abort` out 1: one-cycle pulse when a frame is aborted by timeout.
- `frame_cnt` out 16: frames completed (last byte accepted), wraps at 0xFFFF→0.

## Operation
- State machine has two states: IDLE and STREAM.
- **IDLE**
  - If any `req_valid` is set, select the first set bit searching from `last_grant+1` upward, modulo N_REQ.
  - Register that index into `grant_id` and `last_grant`, then go to STREAM.
  - All `req_ready` and `out_valid` are 0.
- **STREAM** (g = `grant_id`)
  - The output path is a combinational mux: `out_data`=`req_data[g]`, `out_valid`=`req_valid[g]`, `out_last`=`req_last[g]`.
  - `req_ready[g]`=`out_ready`; all other `req_ready` are 0.
  - A beat transfers when `out_valid` and `out_ready` are both high.
  - On a transfer with `out_last`=1: increment `frame_cnt` and go to IDLE.
  - `req_valid[g]` dropping mid-frame is legal; the output simply shows `out_valid`=0 and the grant is kept.
- Requesters must not wait for `req_ready` before asserting `req_valid`. Once asserted, valid/data/last hold until accepted.
- Non-granted requesters are never dropped. They wait until their turn in the rotation.
- Reset values:
  - state IDLE, `grant_id`=0, `last_grant`=N_REQ-1 (requester 0 has first priority), `frame_cnt`=0.
  - `busy`=0, `frame_abort`=0, `out_valid`=0, `out_last`=0, `out_data`=0 (the mux output is forced to 0 in IDLE), all `req_ready`=0.
- Reset asserted mid-frame returns to IDLE on the next edge with no abort pulse. Downstream handles the truncated frame.

## Timing
- Arbitration latency: `req_valid` seen in IDLE at cycle t, so STREAM and `out_valid` at t+1.
- In STREAM, throughput is one byte per cycle with zero added latency (combinational path).
- Between frames there is exactly one IDLE bubble cycle, even if requesters are waiting.
- Simultaneous requests: the rotation is decided solely by `last_grant`. With all requesters valid, grant order is 0,1,2,3,0,...
- A single-byte frame (`last` on the first beat) occupies one STREAM cycle when `out_ready`=1.
- `busy` is registered with the state: high from t+1 through the cycle of the last transfer.

## Configuration
- `SLIP_TX_ARB_TIMEOUT_EN` defined:
  - A 16-bit stall counter runs in STREAM, incrementing on each cycle with `req_valid[g]`=0.
  - The counter clears on any transfer and on entering STREAM.
  - When it reaches TIMEOUT_CYC, the arbiter pulses `frame_abort` for one cycle, goes to IDLE without incrementing `frame_cnt`, and rotation proceeds from g.
  - Stalls caused by `out_ready`=0 with `req_valid[g]`=1 do not count.
- Not defined: no counter, `frame_abort` is tied 0, and a grant is held indefinitely until `last`.

## Test plan
- Reset, then requester 2 sends a 3-byte frame 0x11,0x22,0x33 (last on 0x33), `out_ready`=1:
  - `grant_id`=2 and `busy`=1 one cycle after valid.
  - Output bytes appear on consecutive cycles, `out_last` on 0x33.
  - `frame_cnt`=1, back in IDLE the next cycle.
- All 4 requesters continuously send 2-byte frames: grant order is 0,1,2,3,0, with one idle bubble between frames and `frame_cnt`=5 after five frames.
- Requester 1 mid-frame while requester 0 asserts valid: requester 0's `req_ready` stays 0 until requester 1's last is accepted, then requester 0 is granted.
- Backpressure: `out_ready` toggles 1,0,0,1 during a 4-byte frame. Bytes are neither duplicated nor lost, and the granted `req_ready` mirrors `out_ready`.
- With `SLIP_TX_ARB_TIMEOUT_EN`, TIMEOUT_CYC=8, requester 3 sends one byte then drops valid:
  - `frame_abort` pulses 8 cycles after the last transfer.
  - `frame_cnt` is unchanged and the next grant goes to requester 0 if it is valid.
- Reset asserted mid-frame: next cycle state is IDLE, `busy`=0, `frame_cnt`=0, and requester 0 has first priority.
